bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 148 ++++++++++++++
 tb/tb_bcd_to_bin.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Four-digit BCD to 16-bit binary converter using repeated weight addition, one add per clock.
// Optional digit validation is compiled in with BCD_TO_BIN_DIGIT_CHECK_EN.
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  millares_input,
    input  logic [3:0]  centenas_input,
    input  logic [3:0]  decenas_input,
    input  logic [3:0]  unidades_input,
    output logic [15:0] numero_output,
    output logic        busy,
    output logic        ready,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MILLARES = 3'd1,
        CENTENAS = 3'd2,
        DECENAS  = 3'd3,
        UNIDADES = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cm_reg, cm_next;
    logic [3:0]  cc_reg, cc_next;
    logic [3:0]  cd_reg, cd_next;
    logic [3:0]  cu_reg, cu_next;
    logic [15:0] acc_reg, acc_next;
    logic [15:0] numero_reg, numero_next;
    logic        ready_reg, ready_next;
    logic        error_reg, error_next;
    logic        digit_bad;

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    logic [3:0] digit_in [4];
    logic [3:0] bad_vec;

    assign digit_in[0] = millares_input;
    assign digit_in[1] = centenas_input;
    assign digit_in[2] = decenas_input;
    assign digit_in[3] = unidades_input;

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_check
        assign bad_vec[gi] = (digit_in[gi] > 4'd9);
    end

    assign digit_bad = |bad_vec;
`else
    // Without validation, digits above 9 are simply weighted like any other value.
    assign digit_bad = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        cm_next     = cm_reg;
        cc_next     = cc_reg;
        cd_next     = cd_reg;
        cu_next     = cu_reg;
        acc_next    = acc_reg;
        numero_next = numero_reg;
        ready_next  = 1'b0;
        error_next  = error_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (digit_bad) begin
                        // Rejected request: flag it and finish immediately without converting.
                        error_next = 1'b1;
                        ready_next = 1'b1;
                    end else begin
                        cm_next    = millares_input;
                        cc_next    = centenas_input;
                        cd_next    = decenas_input;
                        cu_next    = unidades_input;
                        acc_next   = 16'd0;
                        error_next = 1'b0;
                        state_next = MILLARES;
                    end
                end
            end
            MILLARES: begin
                if (cm_reg != 4'd0) begin
                    acc_next = acc_reg + 16'd1000;
                    cm_next  = cm_reg - 4'd1;
                end else begin
                    state_next = CENTENAS;
                end
            end
            CENTENAS: begin
                if (cc_reg != 4'd0) begin
                    acc_next = acc_reg + 16'd100;
                    cc_next  = cc_reg - 4'd1;
                end else begin
                    state_next = DECENAS;
                end
            end
            DECENAS: begin
                if (cd_reg != 4'd0) begin
                    acc_next = acc_reg + 16'd10;
                    cd_next  = cd_reg - 4'd1;
                end else begin
                    state_next = UNIDADES;
                end
            end
            UNIDADES: begin
                numero_next = acc_reg + {12'd0, cu_reg};
                ready_next  = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cm_reg     <= 4'd0;
            cc_reg     <= 4'd0;
            cd_reg     <= 4'd0;
            cu_reg     <= 4'd0;
            acc_reg    <= 16'd0;
            numero_reg <= 16'd0;
            ready_reg  <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cm_reg     <= cm_next;
            cc_reg     <= cc_next;
            cd_reg     <= cd_next;
            cu_reg     <= cu_next;
            acc_reg    <= acc_next;
            numero_reg <= numero_next;
            ready_reg  <= ready_next;
            error_reg  <= error_next;
        end
    end

    assign numero_output = numero_reg;
    assign busy          = (state_reg != IDLE);
    assign ready         = ready_reg;
    assign error         = error_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus randomized conversions
// compared against an arithmetic reference model.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  millares_input;
    logic [3:0]  centenas_input;
    logic [3:0]  decenas_input;
    logic [3:0]  unidades_input;
    logic [15:0] numero_output;
    logic        busy;
    logic        ready;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_result = 16'd0;

    bcd_to_bin dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .millares_input (millares_input),
        .centenas_input (centenas_input),
        .decenas_input  (decenas_input),
        .unidades_input (unidades_input),
        .numero_output  (numero_output),
        .busy           (busy),
        .ready          (ready),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain decimal weighting of the digits.
    function automatic logic [15:0] exp_val(input int m, input int c, input int d, input int u);
        return 16'(m * 1000 + c * 100 + d * 10 + u);
    endfunction

    function automatic bit exp_bad(input int m, input int c, input int d, input int u);
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        return (m > 9) || (c > 9) || (d > 9) || (u > 9);
`else
        return 1'b0;
`endif
    endfunction

    // Edges after the capture edge until ready; a rejected request reports on the capture edge.
    function automatic int exp_lat(input int m, input int c, input int d, input int u);
        if (exp_bad(m, c, d, u)) return 0;
        return m + c + d + 4;
    endfunction

    // Drives one request and measures what the DUT does; callers do the comparisons.
    task automatic run_conv(input logic [3:0] m, input logic [3:0] c, input logic [3:0] d,
                            input logic [3:0] u, input bit disturb,
                            output int lat, output logic [15:0] res, output logic err,
                            output int busy_cycles, output bit hold_ok,
                            output logic busy_at_ready, output logic ready_after);
        millares_input = m;
        centenas_input = c;
        decenas_input  = d;
        unidades_input = u;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        busy_cycles = 0;
        hold_ok = 1'b1;
        if (ready === 1'b1) begin
            lat = 0;
        end else begin
            for (int n = 1; n <= 80; n++) begin
                if (busy === 1'b1) busy_cycles++;
                if (numero_output !== prev_result) hold_ok = 1'b0;
                if (disturb) begin
                    millares_input = 4'($urandom_range(0, 15));
                    centenas_input = 4'($urandom_range(0, 15));
                    decenas_input  = 4'($urandom_range(0, 15));
                    unidades_input = 4'($urandom_range(0, 15));
                    start = 1'b1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (ready === 1'b1) begin
                    lat = n;
                    break;
                end
            end
        end
        res = numero_output;
        err = error;
        busy_at_ready = busy;
        @(posedge clk); #1;
        ready_after = ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        millares_input = 4'd0;
        centenas_input = 4'd0;
        decenas_input  = 4'd0;
        unidades_input = 4'd0;
        #1;
        checks++;
        if ({numero_output, busy, ready, error} !== 19'd0) begin
            errors++;
            $display("FAIL reset_async got %h want 0", {numero_output, busy, ready, error});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({numero_output, busy, ready, error} !== 19'd0) begin
            errors++;
            $display("FAIL reset_idle got %h want 0", {numero_output, busy, ready, error});
        end
        prev_result = 16'd0;
    endtask

    task automatic test_zero();
        int lat, bc; logic [15:0] res; logic err, bar, ra; bit hold;
        run_conv(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, lat, res, err, bc, hold, bar, ra);
        $display("conv 0000 lat=%0d result=%0d", lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency got %0d want 4", lat); end
        checks++; if (res !== 16'd0) begin errors++; $display("FAIL zero_result got %0d want 0", res); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL zero_busy_cycles got %0d want 4", bc); end
        checks++; if (bar !== 1'b0) begin errors++; $display("FAIL zero_busy_at_ready got %b want 0", bar); end
        prev_result = 16'd0;
    endtask

    task automatic test_max();
        int lat, bc; logic [15:0] res; logic err, bar, ra; bit hold;
        run_conv(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, lat, res, err, bc, hold, bar, ra);
        $display("conv 9999 lat=%0d result=%0d", lat, res);
        checks++; if (lat !== 31) begin errors++; $display("FAIL max_latency got %0d want 31", lat); end
        checks++; if (res !== 16'd9999) begin errors++; $display("FAIL max_result got %0d want 9999", res); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL max_ready_width got %b want 0", ra); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL max_hold_prev got %b want 1", hold); end
        prev_result = 16'd9999;
    endtask

    task automatic test_ignore_busy();
        int lat, bc; logic [15:0] res; logic err, bar, ra; bit hold;
        run_conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, lat, res, err, bc, hold, bar, ra);
        $display("conv 1234 (disturbed) lat=%0d result=%0d", lat, res);
        checks++; if (res !== 16'd1234) begin errors++; $display("FAIL busy_result got %0d want 1234", res); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL busy_latency got %0d want 10", lat); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL busy_hold_prev got %b want 1", hold); end
        checks++; if ({ra, busy} !== 2'b00) begin errors++; $display("FAIL busy_no_requeue got %b want 00", {ra, busy}); end
        prev_result = 16'd1234;
    endtask

    task automatic test_reset_abort();
        int lat, bc, seen; logic [15:0] res; logic err, bar, ra; bit hold;
        millares_input = 4'd5; centenas_input = 4'd0; decenas_input = 4'd0; unidades_input = 4'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({numero_output, busy, ready, error} !== 19'd0) begin
            errors++;
            $display("FAIL abort_async got %h want 0", {numero_output, busy, ready, error});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prev_result = 16'd0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (ready === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ready got %0d want 0", seen); end
        run_conv(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, lat, res, err, bc, hold, bar, ra);
        $display("conv 0042 after reset lat=%0d result=%0d", lat, res);
        checks++; if (res !== 16'd42) begin errors++; $display("FAIL abort_next_result got %0d want 42", res); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL abort_next_latency got %0d want 8", lat); end
        prev_result = 16'd42;
    endtask

    task automatic test_invalid_digit();
        int lat, bc; logic [15:0] res; logic err, bar, ra; bit hold;
        run_conv(4'd0, 4'd12, 4'd0, 4'd0, 1'b0, lat, res, err, bc, hold, bar, ra);
        $display("conv 0,12,0,0 lat=%0d result=%0d error=%b", lat, res, err);
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_error got %b want 1", err); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL invalid_latency got %0d want 0", lat); end
        checks++; if (res !== prev_result) begin errors++; $display("FAIL invalid_result got %0d want %0d", res, prev_result); end
        checks++; if (bar !== 1'b0) begin errors++; $display("FAIL invalid_busy got %b want 0", bar); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL invalid_error_hold got %b want 1", error); end
        run_conv(4'd0, 4'd0, 4'd0, 4'd5, 1'b0, lat, res, err, bc, hold, bar, ra);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL invalid_error_clear got %b want 0", err); end
        checks++; if (res !== 16'd5) begin errors++; $display("FAIL invalid_next_result got %0d want 5", res); end
        prev_result = 16'd5;
`else
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL invalid_error got %b want 0", err); end
        checks++; if (res !== 16'd1200) begin errors++; $display("FAIL invalid_result got %0d want 1200", res); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL invalid_latency got %0d want 16", lat); end
        prev_result = 16'd1200;
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        millares_input = 4'd0; centenas_input = 4'd0; decenas_input = 4'd1; unidades_input = 4'd0;
        start = 1'b1;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin lat = n; break; end
        end
        checks++; if (numero_output !== 16'd10) begin errors++; $display("FAIL b2b_first got %0d want 10", numero_output); end
        unidades_input = 4'd3;
        decenas_input  = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if ({busy, ready} !== 2'b10) begin errors++; $display("FAIL b2b_restart got %b want 10", {busy, ready}); end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin lat = n; break; end
        end
        $display("conv b2b 0003 lat=%0d result=%0d", lat, numero_output);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", lat); end
        checks++; if (numero_output !== 16'd3) begin errors++; $display("FAIL b2b_result got %0d want 3", numero_output); end
        @(posedge clk); #1;
        prev_result = 16'd3;
    endtask

    task automatic test_random();
        int lat, bc, m, c, d, u, el;
        logic [15:0] res, ev;
        logic err, bar, ra;
        bit hold, bad;
        for (int i = 0; i < 25; i++) begin
            m = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            c = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            u = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            bad = exp_bad(m, c, d, u);
            ev  = bad ? prev_result : exp_val(m, c, d, u);
            el  = exp_lat(m, c, d, u);
            run_conv(4'(m), 4'(c), 4'(d), 4'(u), 1'($urandom_range(0, 1)), lat, res, err, bc, hold, bar, ra);
            $display("conv rnd %0d,%0d,%0d,%0d lat=%0d result=%0d error=%b", m, c, d, u, lat, res, err);
            checks++; if (res !== ev) begin errors++; $display("FAIL rnd_result got %0d want %0d", res, ev); end
            checks++; if (lat !== el) begin errors++; $display("FAIL rnd_latency got %0d want %0d", lat, el); end
            checks++; if (err !== bad) begin errors++; $display("FAIL rnd_error got %b want %b", err, bad); end
            checks++; if (bc !== el) begin errors++; $display("FAIL rnd_busy_cycles got %0d want %0d", bc, el); end
            checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rnd_hold_prev got %b want 1", hold); end
            checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rnd_ready_width got %b want 0", ra); end
            prev_result = ev;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_ignore_busy();
        test_reset_abort();
        test_invalid_digit();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
